// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master RAM / memory-mapped I/O arbiter.
package mem_bus_pkg;

    localparam int unsigned AW     = 9;
    localparam int unsigned DW     = 16;
    localparam int unsigned RAM_AW = 8;
    localparam int unsigned IO_W   = 8;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_ACCESS   = 2'b01;
    localparam logic [1:0] ST_COMPLETE = 2'b10;

    localparam logic [AW-1:0] LED_ADDR = 9'h100;
    localparam logic [AW-1:0] SW_ADDR  = 9'h140;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_req_t;

    // Illegal command, or I/O-space access that is neither an LED write nor a switch read.
    function automatic logic is_bus_err(input bus_req_t r);
        logic bad_cmd;
        logic io_ok;
        bad_cmd = (r.cmd != MREAD) && (r.cmd != MWRITE);
        io_ok   = ((r.cmd == MWRITE) && (r.addr == LED_ADDR)) ||
                  ((r.cmd == MREAD)  && (r.addr == SW_ADDR));
        return bad_cmd || (r.addr[AW-1] && !io_ok);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter, the RAM and the LED/switch I/O.
interface mem_bus_arbiter_if;
    import mem_bus_pkg::*;

    logic              req0, req1;
    logic [1:0]        cmd0, cmd1;
    logic [AW-1:0]     addr0, addr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic              done0, done1;
    logic [DW-1:0]     rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_write;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_dout;
    logic [IO_W-1:0]   sw_in;
    logic              led_load;
    logic [IO_W-1:0]   led_data;
    logic              busy;
    logic              owner;
    logic              bus_err;

    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, ram_dout, sw_in,
        output done0, done1, rdata, ram_addr, ram_write, ram_wdata,
               led_load, led_data, busy, owner, bus_err
    );

    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, ram_dout, sw_in,
        input  done0, done1, rdata, ram_addr, ram_write, ram_wdata,
               led_load, led_data, busy, owner, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-input round-robin picker; the caller owns the "last granted" register.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_i,
    output logic       gnt_o,
    output logic       valid_o
);
    logic [1:0] eff_req;

    assign eff_req = req_i & ~mask_i;

    always_comb begin
        valid_o = |eff_req;
        case (eff_req)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ~last_i;
            default: gnt_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the 256x16 RAM, LED register and switches between two masters.
module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    bus_req_t          lat_q, lat_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0]     ram_wdata_q, ram_wdata_d;
    logic              ram_write_q, ram_write_d;
    logic              led_load_q, led_load_d;
    logic [IO_W-1:0]   led_data_q, led_data_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              bus_err_q, bus_err_d;
    logic              busy_q, busy_d;
    logic              rd_ram_q, rd_ram_d;
    logic              rd_sw_q, rd_sw_d;

    logic [1:0]        req_vec;
    logic [1:0]        arb_mask;
    logic              arb_gnt;
    logic              arb_valid;
    bus_req_t          cand;

    // MNONE is not a request; the finishing owner is masked so the other port goes next.
    assign req_vec  = {bus.req1 && (bus.cmd1 != MNONE), bus.req0 && (bus.cmd0 != MNONE)};
    assign arb_mask = (state_q == ST_COMPLETE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign cand     = arb_gnt ? {bus.cmd1, bus.addr1, bus.wdata1}
                              : {bus.cmd0, bus.addr0, bus.wdata0};

    rr_arb2 u_arb (
        .req_i   (req_vec),
        .mask_i  (arb_mask),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    // Next state; strobes are precomputed for the state being entered so they leave flops.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_write_d = 1'b0;
        led_load_d  = 1'b0;
        led_data_d  = '0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        bus_err_d   = 1'b0;
        rd_ram_d    = 1'b0;
        rd_sw_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_COMPLETE: begin
                if (arb_valid) begin
                    state_d = ST_ACCESS;
                    owner_d = arb_gnt;
                    last_d  = arb_gnt;
                    lat_d   = cand;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d   = ST_COMPLETE;
                done0_d   = ~owner_q;
                done1_d   = owner_q;
                bus_err_d = is_bus_err(lat_q);
                rd_ram_d  = (lat_q.cmd == MREAD) && !lat_q.addr[AW-1];
                rd_sw_d   = (lat_q.cmd == MREAD) && (lat_q.addr == SW_ADDR);
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ACCESS) begin
            ram_addr_d  = lat_d.addr[RAM_AW-1:0];
            ram_wdata_d = lat_d.wdata;
            ram_write_d = (lat_d.cmd == MWRITE) && !lat_d.addr[AW-1];
            led_load_d  = (lat_d.cmd == MWRITE) && (lat_d.addr == LED_ADDR);
            led_data_d  = lat_d.wdata[IO_W-1:0];
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            lat_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_write_q <= 1'b0;
            led_load_q  <= 1'b0;
            led_data_q  <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_ram_q    <= 1'b0;
            rd_sw_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_write_q <= ram_write_d;
            led_load_q  <= led_load_d;
            led_data_q  <= led_data_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            bus_err_q   <= bus_err_d;
            busy_q      <= busy_d;
            rd_ram_q    <= rd_ram_d;
            rd_sw_q     <= rd_sw_d;
        end
    end

    // RAM data only exists after the ACCESS edge, so the read mux sits after the flops.
    assign bus.rdata     = rd_ram_q ? bus.ram_dout : (rd_sw_q ? DW'(bus.sw_in) : '0);
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_write = ram_write_q;
    assign bus.led_load  = led_load_q;
    assign bus.led_data  = led_data_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule
